multi_channel_pulse_generator: RTL and testbench

Parametrised successor to the single-channel TTL pulse generator. Provides NUM_CH independent channels. Each channel has a programmable start delay, pulse width, period, pulse count (0 = continuous), output polarity and a start/stop/busy/done handshake. It sits behind the top-level pin wrapper and drives TTL outputs directly; the configuration source (fixed table or register file) is external.

---
 rtl/multi_channel_pulse_generator.sv | 134 +++++++++++++
 tb/tb_multi_channel_pulse_generator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_pulse_generator.sv
// NUM_CH independent TTL pulse channels, each with a latched delay/width/period/count
// configuration, selectable output polarity and a start/stop/busy/done handshake.
module multi_channel_pulse_generator #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int NUM_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         stop,
  input  logic [NUM_CH*CNT_W-1:0]   cfg_delay,
  input  logic [NUM_CH*CNT_W-1:0]   cfg_width,
  input  logic [NUM_CH*CNT_W-1:0]   cfg_period,
  input  logic [NUM_CH*NUM_W-1:0]   cfg_count,
  input  logic [NUM_CH-1:0]         cfg_invert,
  output logic [NUM_CH-1:0]         pulse_out,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         done
);

  typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [NUM_W-1:0] ONE_N = NUM_W'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] dly_cnt;
    logic [CNT_W-1:0] pos;
    logic [CNT_W-1:0] wid_l;
    logic [CNT_W-1:0] per_l;
    logic [NUM_W-1:0] rem;
    logic             inv_l;
    logic             pulse_r;
    logic             busy_r;
    logic             done_r;

    logic [CNT_W-1:0] d_in, w_in, p_in;
    logic [NUM_W-1:0] n_in;

    assign d_in = cfg_delay[i*CNT_W +: CNT_W];
    assign w_in = cfg_width[i*CNT_W +: CNT_W];
    assign p_in = cfg_period[i*CNT_W +: CNT_W];
    assign n_in = cfg_count[i*NUM_W +: NUM_W];

    assign pulse_out[i] = pulse_r;
    assign busy[i]      = busy_r;
    assign done[i]      = done_r;

    // pos is the position of the current cycle within its period; rem counts
    // periods still to run, and stays 0 forever in continuous mode.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state   <= IDLE;
        dly_cnt <= '0;
        pos     <= '0;
        wid_l   <= '0;
        per_l   <= '0;
        rem     <= '0;
        inv_l   <= 1'b0;
        pulse_r <= 1'b0;
        busy_r  <= 1'b0;
        done_r  <= 1'b0;
      end else begin
        done_r <= 1'b0;
        case (state)
          IDLE: begin
            pulse_r <= cfg_invert[i];
            busy_r  <= 1'b0;
            if (start[i] && !stop[i]) begin
              inv_l <= cfg_invert[i];
              wid_l <= (w_in > p_in) ? p_in : w_in;
              per_l <= p_in;
              rem   <= n_in;
              pos   <= '0;
              if (w_in == '0 || p_in == '0) begin
                done_r <= 1'b1;
              end else begin
                busy_r <= 1'b1;
                if (d_in != '0) begin
                  state   <= DELAY;
                  dly_cnt <= d_in - ONE_C;
                end else begin
                  state   <= HIGH;
                  pulse_r <= ~cfg_invert[i];
                end
              end
            end
          end
          default: begin
            if (stop[i]) begin
              state   <= IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              pulse_r <= cfg_invert[i];
            end else if (state == DELAY) begin
              if (dly_cnt == '0) begin
                state   <= HIGH;
                pos     <= '0;
                pulse_r <= ~inv_l;
              end else begin
                dly_cnt <= dly_cnt - ONE_C;
              end
            end else if (pos == per_l - ONE_C) begin
              // Last cycle of a period: either finish or begin the next pulse.
              if (rem == ONE_N) begin
                state   <= IDLE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                pulse_r <= cfg_invert[i];
              end else begin
                if (rem != '0) rem <= rem - ONE_N;
                pos     <= '0;
                state   <= HIGH;
                pulse_r <= ~inv_l;
              end
            end else begin
              pos <= pos + ONE_C;
              if (pos + ONE_C < wid_l) begin
                state   <= HIGH;
                pulse_r <= ~inv_l;
              end else begin
                state   <= LOW;
                pulse_r <= inv_l;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_pulse_generator.sv
// Bench for multi_channel_pulse_generator: directed scenarios followed by randomized
// start/stop/config/reset traffic, all checked against a cycle-indexed arithmetic model.
module tb_multi_channel_pulse_generator;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int NUM_W  = 16;
  localparam int FOREVER_C = 1 << 30;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       start = '0;
  logic [NUM_CH-1:0]       stop = '0;
  logic [NUM_CH*CNT_W-1:0] cfg_delay = '0;
  logic [NUM_CH*CNT_W-1:0] cfg_width = '0;
  logic [NUM_CH*CNT_W-1:0] cfg_period = '0;
  logic [NUM_CH*NUM_W-1:0] cfg_count = '0;
  logic [NUM_CH-1:0]       cfg_invert = '0;
  logic [NUM_CH-1:0]       pulse_out, busy, done;

  multi_channel_pulse_generator #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_period(cfg_period),
    .cfg_count(cfg_count), .cfg_invert(cfg_invert),
    .pulse_out(pulse_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a run started at edge ts occupies cycles ts+1..end_c,
  // and the cycle after end_c carries the done strobe.
  int cyc = 0;
  bit in_reset = 1'b1;
  bit started [NUM_CH];
  int ts [NUM_CH], end_c [NUM_CH];
  int md [NUM_CH], mw [NUM_CH], mp [NUM_CH];
  bit minv [NUM_CH];
  bit inv_prev [NUM_CH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      in_reset = 1'b1;
      for (int ch = 0; ch < NUM_CH; ch++) started[ch] = 1'b0;
    end else begin
      in_reset = 1'b0;
      cyc++;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        int d, w, p, n;
        bit running;
        d = int'(cfg_delay[ch*CNT_W +: CNT_W]);
        w = int'(cfg_width[ch*CNT_W +: CNT_W]);
        p = int'(cfg_period[ch*CNT_W +: CNT_W]);
        n = int'(cfg_count[ch*NUM_W +: NUM_W]);
        running = started[ch] && ts[ch] < cyc && cyc <= end_c[ch];
        if (running) begin
          if (stop[ch]) end_c[ch] = cyc;
        end else if (start[ch] && !stop[ch]) begin
          started[ch] = 1'b1;
          ts[ch]   = cyc;
          md[ch]   = d;
          mp[ch]   = p;
          mw[ch]   = (w > p) ? p : w;
          minv[ch] = cfg_invert[ch];
          if (w == 0 || p == 0) end_c[ch] = cyc;
          else if (n == 0)      end_c[ch] = FOREVER_C;
          else                  end_c[ch] = cyc + d + n * p;
        end
        inv_prev[ch] = cfg_invert[ch];
      end
    end
  end

  bit checking = 1'b1;

  always @(negedge clk) begin
    if (checking) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        int c, rel, q;
        bit eb, ed, ep;
        c  = cyc + 1;
        eb = started[ch] && ts[ch] < c && c <= end_c[ch];
        ed = started[ch] && c == end_c[ch] + 1;
        ep = inv_prev[ch];
        if (eb) begin
          rel = c - ts[ch];
          if (rel <= md[ch]) ep = minv[ch];
          else begin
            q  = (rel - md[ch] - 1) % mp[ch];
            ep = (q < mw[ch]) ? !minv[ch] : minv[ch];
          end
        end
        if (rst || in_reset) begin
          eb = 1'b0; ed = 1'b0; ep = 1'b0;
        end
        check($sformatf("pulse ch%0d c%0d", ch, c), 32'(pulse_out[ch]), 32'(ep));
        check($sformatf("busy ch%0d c%0d", ch, c), 32'(busy[ch]), 32'(eb));
        check($sformatf("done ch%0d c%0d", ch, c), 32'(done[ch]), 32'(ed));
      end
    end
  end

  task automatic set_cfg(input int ch, input int d, input int w, input int p,
                         input int n, input bit inv);
    cfg_delay[ch*CNT_W +: CNT_W]  = CNT_W'(d);
    cfg_width[ch*CNT_W +: CNT_W]  = CNT_W'(w);
    cfg_period[ch*CNT_W +: CNT_W] = CNT_W'(p);
    cfg_count[ch*NUM_W +: NUM_W]  = NUM_W'(n);
    cfg_invert[ch]                = inv;
  endtask

  // Inputs change 1 time unit after the falling edge, clear of both check and sample points.
  task automatic step(input int k);
    repeat (k) begin
      @(negedge clk);
      #1;
      start = '0;
      stop  = '0;
    end
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    step(2);

    // Ch0 basic run; re-pulsed start and config churn mid-run must not disturb it.
    set_cfg(0, 0, 3, 10, 2, 1'b0);
    start[0] = 1'b1;
    step(4);
    set_cfg(0, 2, 5, 6, 1, 1'b0);
    start[0] = 1'b1;
    step(24);

    // Ch1 delayed, inverted single pulse.
    set_cfg(1, 5, 2, 4, 1, 1'b1);
    start[1] = 1'b1;
    step(13);

    // Ch2 continuous run ended by stop.
    set_cfg(2, 0, 1, 3, 0, 1'b0);
    start[2] = 1'b1;
    step(8);
    stop[2] = 1'b1;
    step(5);

    // Ch3 degenerate width, degenerate period, then width clamped to period.
    set_cfg(3, 0, 0, 5, 1, 1'b0);
    start[3] = 1'b1;
    step(3);
    set_cfg(3, 0, 4, 0, 1, 1'b0);
    start[3] = 1'b1;
    step(3);
    set_cfg(3, 0, 7, 5, 2, 1'b0);
    start[3] = 1'b1;
    step(14);

    // Start and stop together in IDLE, then start coinciding with done.
    set_cfg(0, 1, 2, 3, 1, 1'b0);
    start[0] = 1'b1;
    stop[0]  = 1'b1;
    step(4);
    start[0] = 1'b1;
    step(4);
    start[0] = 1'b1;
    step(6);

    // All channels together, then reset mid-run.
    set_cfg(0, 0, 2, 5, 0, 1'b0);
    set_cfg(1, 3, 1, 2, 3, 1'b1);
    set_cfg(2, 1, 4, 4, 2, 1'b0);
    set_cfg(3, 2, 3, 7, 0, 1'b1);
    start = '1;
    step(7);
    rst = 1'b1;
    #1;
    check("async_rst", 32'({pulse_out, busy, done}), 32'd0);
    step(2);
    rst = 1'b0;
    step(5);

    for (int it = 0; it < 3000; it++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        set_cfg(ch, $urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 7),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        start[ch] = ($urandom_range(0, 5) == 0);
        stop[ch]  = ($urandom_range(0, 24) == 0);
      end
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
      else rst = 1'b0;
      @(negedge clk);
      #1;
    end
    rst = 1'b0;
    start = '0;
    stop = '0;
    step(3);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
